// File: rtl/avalon_engine_regbank_pkg.sv
// Shared definitions for the Avalon-MM engine register bank.
package avalon_engine_regbank_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_BUSY  = 2'd2,
    ST_DONE  = 2'd3
  } eng_state_e;

  // CTRL register bit positions
  localparam int unsigned CTRL_START  = 0;
  localparam int unsigned CTRL_ACK    = 1;
  localparam int unsigned CTRL_IRQ_EN = 2;

  // STATUS register bit positions
  localparam int unsigned STAT_BUSY    = 0;
  localparam int unsigned STAT_DONE    = 1;
  localparam int unsigned STAT_TIMEOUT = 2;
  localparam int unsigned STAT_OVERRUN = 3;

  // Register offsets as functions of the register count
  function automatic int unsigned num_gp(input int unsigned num_regs);
    return num_regs - 3;
  endfunction

  function automatic int unsigned result_idx(input int unsigned num_regs);
    return num_regs - 3;
  endfunction

  function automatic int unsigned ctrl_idx(input int unsigned num_regs);
    return num_regs - 2;
  endfunction

  function automatic int unsigned status_idx(input int unsigned num_regs);
    return num_regs - 1;
  endfunction

endpackage

// File: rtl/avalon_engine_regbank_engine_ctrl_fsm.sv
// Engine sequencing FSM with saturating timeout counter and status flags.
module engine_ctrl_fsm
  import avalon_engine_regbank_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_req,
  input  logic ack_req,
  input  logic eng_done,
  output logic eng_start,
  output logic busy,
  output logic done,
  output logic timeout,
  output logic overrun,
  output logic capture_c
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  eng_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             tmo_hit_c;

  // Timeout fires on the TIMEOUT-th BUSY cycle; disabled when TIMEOUT is 0
  assign tmo_hit_c = (TIMEOUT != 0) && (cnt_q == CNT_LAST);
  assign capture_c = (state_q == ST_BUSY) && eng_done;

  // State, counter and registered status/pulse outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      eng_start <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      eng_start <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_req) begin
            state_q   <= ST_START;
            eng_start <= 1'b1;
            busy      <= 1'b1;
          end
        end
        ST_START: begin
          state_q <= ST_BUSY;
          cnt_q   <= '0;
          if (start_req) overrun <= 1'b1;
        end
        ST_BUSY: begin
          if (start_req) overrun <= 1'b1;
          if (eng_done) begin
            done    <= 1'b1;
            busy    <= 1'b0;
            state_q <= ST_DONE;
          end else if (tmo_hit_c) begin
            timeout <= 1'b1;
            busy    <= 1'b0;
            state_q <= ST_DONE;
          end else if (cnt_q != CNT_LAST) begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        ST_DONE: begin
          // ACK takes priority over a START in the same write
          if (ack_req) begin
            done    <= 1'b0;
            timeout <= 1'b0;
            overrun <= 1'b0;
            state_q <= ST_IDLE;
          end else if (start_req) begin
            overrun <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/avalon_engine_regbank.sv
// Avalon-MM register bank fronting a start/done compute engine.
module avalon_engine_regbank
  import avalon_engine_regbank_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned NUM_REGS   = 16,
  parameter int unsigned EXPORT_IDX = 0,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                              clk_clk,
  input  logic                              reset_reset_n,
  input  logic [$clog2(NUM_REGS)-1:0]       avs_address,
  input  logic                              avs_chipselect,
  input  logic                              avs_read,
  input  logic                              avs_write,
  input  logic [DATA_W/8-1:0]               avs_byteenable,
  input  logic [DATA_W-1:0]                 avs_writedata,
  output logic [DATA_W-1:0]                 avs_readdata,
  output logic [(NUM_REGS-3)*DATA_W-1:0]    eng_operands,
  output logic                              eng_start,
  input  logic                              eng_done,
  input  logic [DATA_W-1:0]                 eng_result,
  output logic [DATA_W-1:0]                 export_data,
  output logic                              irq
);

  localparam int unsigned AW  = $clog2(NUM_REGS);
  localparam int unsigned BW  = DATA_W / 8;
  localparam int unsigned NGP = num_gp(NUM_REGS);

  logic [DATA_W-1:0] gp_q [NGP];
  logic [DATA_W-1:0] result_q;
  logic              irq_en_q;
  logic [DATA_W-1:0] view_c [NUM_REGS];
  logic              wr_c;
  logic              ctrl_wr_c;
  logic              busy, done, timeout, overrun, capture_c;

  assign wr_c      = avs_chipselect && avs_write;
  assign ctrl_wr_c = wr_c && (avs_address == AW'(ctrl_idx(NUM_REGS)));

  engine_ctrl_fsm #(.TIMEOUT(TIMEOUT)) u_fsm (
    .clk       (clk_clk),
    .rst_n     (reset_reset_n),
    .start_req (ctrl_wr_c && avs_writedata[CTRL_START]),
    .ack_req   (ctrl_wr_c && avs_writedata[CTRL_ACK]),
    .eng_done  (eng_done),
    .eng_start (eng_start),
    .busy      (busy),
    .done      (done),
    .timeout   (timeout),
    .overrun   (overrun),
    .capture_c (capture_c)
  );

  // Byte-lane writes into the general-purpose registers
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      for (int i = 0; i < NGP; i++) gp_q[i] <= '0;
    end else begin
      for (int i = 0; i < NGP; i++) begin
        for (int b = 0; b < BW; b++) begin
          if (wr_c && (avs_address == AW'(i)) && avs_byteenable[b])
            gp_q[i][b*8 +: 8] <= avs_writedata[b*8 +: 8];
        end
      end
    end
  end

  // RESULT capture, IRQ enable and registered interrupt
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      result_q <= '0;
      irq_en_q <= 1'b0;
      irq      <= 1'b0;
    end else begin
      if (capture_c) result_q <= eng_result;
      if (ctrl_wr_c && avs_byteenable[0]) irq_en_q <= avs_writedata[CTRL_IRQ_EN];
      irq <= irq_en_q && (done || timeout);
    end
  end

  // Read view of every register address
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) view_c[i] = '0;
    for (int i = 0; i < NGP; i++) view_c[i] = gp_q[i];
    view_c[result_idx(NUM_REGS)]                = result_q;
    view_c[ctrl_idx(NUM_REGS)][CTRL_IRQ_EN]     = irq_en_q;
    view_c[status_idx(NUM_REGS)][STAT_BUSY]     = busy;
    view_c[status_idx(NUM_REGS)][STAT_DONE]     = done;
    view_c[status_idx(NUM_REGS)][STAT_TIMEOUT]  = timeout;
    view_c[status_idx(NUM_REGS)][STAT_OVERRUN]  = overrun;
  end

  // One-cycle read latency; holds last value when not reading
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) avs_readdata <= '0;
    else if (avs_chipselect && avs_read) avs_readdata <= view_c[avs_address];
  end

  assign export_data = view_c[AW'(EXPORT_IDX)];

  // Flatten GP registers for the engine, reg0 at the LSBs
  for (genvar g = 0; g < NGP; g++) begin : g_ops
    assign eng_operands[g*DATA_W +: DATA_W] = gp_q[g];
  end

endmodule

// File: tb/tb_avalon_engine_regbank.sv
// Directed plus randomized checks of the engine register bank against a reference model.
module tb_avalon_engine_regbank;

  localparam int DW  = 32;
  localparam int NR  = 16;
  localparam int NG  = NR - 3;
  localparam int TO  = 8;
  localparam int OPW = NG * DW;

  logic            clk_clk = 1'b0;
  logic            reset_reset_n;
  logic [3:0]      avs_address;
  logic            avs_chipselect, avs_read, avs_write;
  logic [3:0]      avs_byteenable;
  logic [DW-1:0]   avs_writedata;
  logic [DW-1:0]   avs_readdata;
  logic [OPW-1:0]  eng_operands;
  logic            eng_start;
  logic            eng_done;
  logic [DW-1:0]   eng_result;
  logic [DW-1:0]   export_data;
  logic            irq;

  int errors = 0;
  int checks = 0;

  always #5 clk_clk = ~clk_clk;

  avalon_engine_regbank #(.DATA_W(DW), .NUM_REGS(NR), .EXPORT_IDX(0), .TIMEOUT(TO)) dut (
    .clk_clk        (clk_clk),
    .reset_reset_n  (reset_reset_n),
    .avs_address    (avs_address),
    .avs_chipselect (avs_chipselect),
    .avs_read       (avs_read),
    .avs_write      (avs_write),
    .avs_byteenable (avs_byteenable),
    .avs_writedata  (avs_writedata),
    .avs_readdata   (avs_readdata),
    .eng_operands   (eng_operands),
    .eng_start      (eng_start),
    .eng_done       (eng_done),
    .eng_result     (eng_result),
    .export_data    (export_data),
    .irq            (irq)
  );

  // Reference model: engine phase 0=idle, 1=launching, 2=running, 3=finished
  logic [DW-1:0] m_gp [NG];
  logic [DW-1:0] m_result, m_rdata;
  bit m_irq_en, m_done, m_tmo, m_ovr, m_irq, m_start;
  int m_phase, m_run;

  function automatic logic [DW-1:0] m_view(input int a);
    logic [DW-1:0] v;
    v = '0;
    if (a < NG) v = m_gp[a];
    else if (a == 13) v = m_result;
    else if (a == 14) v[2] = m_irq_en;
    else begin
      v[0] = (m_phase == 1) || (m_phase == 2);
      v[1] = m_done;
      v[2] = m_tmo;
      v[3] = m_ovr;
    end
    return v;
  endfunction

  task automatic m_reset();
    for (int k = 0; k < NG; k++) m_gp[k] = '0;
    m_result = '0; m_rdata = '0;
    m_irq_en = 0; m_done = 0; m_tmo = 0; m_ovr = 0; m_irq = 0; m_start = 0;
    m_phase = 0; m_run = 0;
  endtask

  task automatic m_step();
    int a;
    bit wr, ctl, st, ak;
    a   = int'(avs_address);
    wr  = avs_chipselect && avs_write;
    ctl = wr && (a == 14);
    st  = ctl && avs_writedata[0];
    ak  = ctl && avs_writedata[1];
    if (avs_chipselect && avs_read) m_rdata = m_view(a);
    m_irq   = m_irq_en && (m_done || m_tmo);
    m_start = 0;
    case (m_phase)
      0: if (st) begin m_phase = 1; m_start = 1; end
      1: begin if (st) m_ovr = 1; m_phase = 2; m_run = 0; end
      2: begin
        if (st) m_ovr = 1;
        m_run++;
        if (eng_done) begin m_result = eng_result; m_done = 1; m_phase = 3; end
        else if (m_run == TO) begin m_tmo = 1; m_phase = 3; end
      end
      default: begin
        if (ak) begin m_done = 0; m_tmo = 0; m_ovr = 0; m_phase = 0; end
        else if (st) m_ovr = 1;
      end
    endcase
    if (wr && a < NG)
      for (int b = 0; b < 4; b++)
        if (avs_byteenable[b]) m_gp[a][b*8 +: 8] = avs_writedata[b*8 +: 8];
    if (ctl && avs_byteenable[0]) m_irq_en = avs_writedata[2];
  endtask

  task automatic check(input string tag, input logic [OPW-1:0] obs, input logic [OPW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    logic [OPW-1:0] ops;
    for (int k = 0; k < NG; k++) ops[k*DW +: DW] = m_gp[k];
    check("readdata", OPW'(avs_readdata), OPW'(m_rdata));
    check("irq", OPW'(irq), OPW'(m_irq));
    check("eng_start", OPW'(eng_start), OPW'(m_start));
    check("export_data", OPW'(export_data), OPW'(m_gp[0]));
    check("eng_operands", eng_operands, ops);
  endtask

  task automatic tick();
    @(posedge clk_clk);
    m_step();
    #1;
    compare_all();
  endtask

  task automatic idle_bus();
    avs_chipselect = 0; avs_read = 0; avs_write = 0;
    avs_byteenable = '0; avs_writedata = '0; avs_address = '0;
  endtask

  task automatic bus_write(input int a, input logic [DW-1:0] d, input logic [3:0] be);
    avs_address = 4'(a); avs_writedata = d; avs_byteenable = be;
    avs_chipselect = 1; avs_write = 1; avs_read = 0;
    tick();
    idle_bus();
  endtask

  task automatic bus_read(input int a);
    avs_address = 4'(a); avs_chipselect = 1; avs_read = 1; avs_write = 0;
    tick();
    idle_bus();
  endtask

  task automatic pulse_done(input logic [DW-1:0] r);
    eng_done = 1; eng_result = r;
    tick();
    eng_done = 0;
  endtask

  initial begin
    reset_reset_n = 0;
    idle_bus();
    eng_done = 0; eng_result = '0;
    m_reset();
    #12;
    check("rst_readdata", OPW'(avs_readdata), '0);
    check("rst_irq", OPW'(irq), '0);
    check("rst_eng_start", OPW'(eng_start), '0);
    check("rst_export", OPW'(export_data), '0);
    check("rst_operands", eng_operands, '0);
    @(negedge clk_clk);
    reset_reset_n = 1;

    // Byte-lane masked write and read-back
    bus_write(0, 32'hDEADBEEF, 4'b0101);
    bus_read(0);
    check("be_read", OPW'(avs_readdata), OPW'(32'h00AD00EF));
    check("be_export", OPW'(export_data), OPW'(32'h00AD00EF));
    check("be_operand0", OPW'(eng_operands[31:0]), OPW'(32'h00AD00EF));

    // Start, complete, interrupt, acknowledge
    bus_write(14, 32'h5, 4'hF);
    check("start_pulse_hi", OPW'(eng_start), OPW'(1'b1));
    tick();
    check("start_pulse_lo", OPW'(eng_start), '0);
    bus_read(15);
    check("status_busy", OPW'(avs_readdata), OPW'(32'h1));
    pulse_done(32'h12345678);
    bus_read(15);
    check("status_done", OPW'(avs_readdata), OPW'(32'h2));
    check("irq_done", OPW'(irq), OPW'(1'b1));
    bus_read(13);
    check("result", OPW'(avs_readdata), OPW'(32'h12345678));
    bus_write(14, 32'h2, 4'hF);
    bus_read(15);
    check("status_ack", OPW'(avs_readdata), '0);
    check("irq_ack", OPW'(irq), '0);

    // START while busy flags overrun without a second pulse
    bus_write(14, 32'h1, 4'hF);
    tick();
    bus_write(14, 32'h1, 4'hF);
    check("no_restart", OPW'(eng_start), '0);
    bus_read(15);
    check("status_overrun", OPW'(avs_readdata), OPW'(32'h9));
    pulse_done(32'h0BADCAFE);
    bus_read(15);
    check("status_done_ovr", OPW'(avs_readdata), OPW'(32'hA));
    bus_write(14, 32'h2, 4'hF);
    bus_read(15);
    check("status_ack2", OPW'(avs_readdata), '0);

    // Timeout after exactly TO busy cycles, RESULT untouched
    bus_write(14, 32'h1, 4'hF);
    tick();
    for (int i = 0; i < TO - 2; i++) tick();
    bus_read(15);
    check("tmo_not_yet", OPW'(avs_readdata), OPW'(32'h1));
    tick();
    bus_read(15);
    check("tmo_status", OPW'(avs_readdata), OPW'(32'h4));
    bus_read(13);
    check("tmo_result", OPW'(avs_readdata), OPW'(32'h0BADCAFE));
    bus_write(14, 32'h2, 4'hF);

    // Done coincident with the timeout cycle: done wins
    bus_write(14, 32'h1, 4'hF);
    tick();
    for (int i = 0; i < TO - 1; i++) tick();
    pulse_done(32'hCAFEF00D);
    bus_read(15);
    check("tie_status", OPW'(avs_readdata), OPW'(32'h2));
    bus_read(13);
    check("tie_result", OPW'(avs_readdata), OPW'(32'hCAFEF00D));
    bus_write(14, 32'h6, 4'hF);

    // Reset in the middle of an operation
    bus_write(3, 32'h11223344, 4'hF);
    bus_write(14, 32'h1, 4'hF);
    tick();
    #2;
    reset_reset_n = 0;
    #1;
    m_reset();
    check("mid_rst_readdata", OPW'(avs_readdata), '0);
    check("mid_rst_irq", OPW'(irq), '0);
    check("mid_rst_start", OPW'(eng_start), '0);
    check("mid_rst_export", OPW'(export_data), '0);
    check("mid_rst_operands", eng_operands, '0);
    @(negedge clk_clk);
    reset_reset_n = 1;
    pulse_done(32'hFFFFFFFF);
    bus_read(13);
    check("post_rst_result", OPW'(avs_readdata), '0);
    bus_read(15);
    check("post_rst_status", OPW'(avs_readdata), '0);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      avs_chipselect = ($urandom_range(0, 3) != 0);
      avs_read       = $urandom_range(0, 1) == 1;
      avs_write      = !avs_read;
      avs_address    = ($urandom_range(0, 2) == 0) ? 4'd14 : 4'($urandom_range(0, 15));
      avs_byteenable = 4'($urandom_range(0, 15));
      avs_writedata  = $urandom;
      eng_done       = ($urandom_range(0, 5) == 0);
      eng_result     = $urandom;
      tick();
    end
    idle_bus();
    eng_done = 0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
